// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   // All segments off on a common-anode, active-low display.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern (bit 6 = G, bit 0 = A).
module seven_segment_decoder (
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = 7'h7F;
      case (nibble)
         4'h0: seg_n = 7'b1000000;
         4'h1: seg_n = 7'b1111001;
         4'h2: seg_n = 7'b0100100;
         4'h3: seg_n = 7'b0110000;
         4'h4: seg_n = 7'b0011001;
         4'h5: seg_n = 7'b0010010;
         4'h6: seg_n = 7'b0000010;
         4'h7: seg_n = 7'b1111000;
         4'h8: seg_n = 7'b0000000;
         4'h9: seg_n = 7'b0010000;
         4'hA: seg_n = 7'b0001000;
         4'hB: seg_n = 7'b0000011;
         4'hC: seg_n = 7'b1000110;
         4'hD: seg_n = 7'b0100001;
         4'hE: seg_n = 7'b0000110;
         4'hF: seg_n = 7'b0001110;
         default: seg_n = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seven_segment_mux_ctrl.sv
// Time-multiplexed seven-segment scheduler with blank/dwell cadence and per-frame snapshot.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking of digits above digit 0.
module seven_segment_mux_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 2,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          en,
   input  logic [4*NUM_DIGITS-1:0]       digits_in,
   output logic [6:0]                    seg_n,
   output logic [NUM_DIGITS-1:0]         anode_n,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_done,
   output logic [1:0]                    dbg_state
);

   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic                    frame_done_q, frame_done_d;

   logic [3:0]              nibble_sel;
   logic [6:0]              dec_seg;
   logic [NUM_DIGITS-1:0]   lz_mask;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      frame_done_d = 1'b0;
      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = '0;
            end
            BLANK: begin
               if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                  state_d = ACTIVE;
                  cnt_d   = '0;
                  // Snapshot once per frame so every digit of a frame is coherent.
                  if (idx_q == '0) shadow_d = digits_in;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ACTIVE: begin
               if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                     idx_d        = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Outputs are derived from the next state so they change on the same edge as the state.
   always_comb begin
      nibble_sel = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) nibble_sel = shadow_d[4*k +: 4];
      end
   end

`ifdef SEVEN_SEG_LZB_EN
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      lz_mask  = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         all_zero   = all_zero && (shadow_d[4*k +: 4] == 4'h0);
         lz_mask[k] = all_zero && (k != 0);
      end
   end
`else
   assign lz_mask = '0;
`endif

   seven_segment_decoder u_decoder (
      .nibble (nibble_sel),
      .seg_n  (dec_seg)
   );

   always_comb begin
      seg_d   = SEG_BLANK;
      anode_d = '1;
      if (state_d == ACTIVE && !lz_mask[idx_d]) begin
         seg_d   = dec_seg;
         anode_d = ~(NUM_DIGITS'(1) << idx_d);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         seg_q        <= SEG_BLANK;
         anode_q      <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         seg_q        <= seg_d;
         anode_q      <= anode_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg_n      = seg_q;
   assign anode_n    = anode_q;
   assign digit_idx  = idx_q;
   assign frame_done = frame_done_q;
   assign dbg_state  = state_q;

endmodule
